mem_arbiter: RTL
================

# mem_arbiter

Parametrised single-clock shared-memory block: an inferred byte-organised RAM behind a round-robin arbiter serving `CHANNELS` requesters (CPU, video fetch, DMA), each able to issue narrow (8-bit) or wide (16-bit) reads and writes. It replaces the fixed two-port CPU/video memory arrangement in the top level with one instance that scales in channel count and address width. It also adds misaligned wide access and per-channel read-return tagging.

## Interface
- `CHANNELS`, 2: number of requesters, 1..8.
- `ADDR_W`, 16: byte-address width.
- `DEPTH`, 65536: RAM size in bytes; power of two, ≤ 2^ADDR_W.
- `CH_W`, derived: $clog2(CHANNELS), minimum 1.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  CHANNELS  per-channel request; held with command stable until `ack`.
- `wr`  in  CHANNELS  1 = write, 0 = read.
- `wide`  in  CHANNELS  1 = 16-bit access, 0 = 8-bit.
- `addr`  in  CHANNELS*ADDR_W  packed byte addresses; channel i at [i*ADDR_W +: ADDR_W].
- `din`  in  CHANNELS*16  packed write data; channel i at [i*16 +: 16].
- `ack`  out  CHANNELS  combinational; one-hot or zero; command consumed at the edge ending this cycle.
- `dout`  out  16  read data, registered.
- `dout_valid`  out  1  one-cycle pulse qualifying `dout`.
- `dout_ch`  out  CH_W  channel that owns `dout`.

## Operation
- States: IDLE, SPLIT.
- IDLE, no `req`: nothing happens; `ack` = 0.
- IDLE, any `req`: winner w = first requesting channel after `last`, searching upward modulo CHANNELS.
- Aligned access (narrow, or wide with addr[0]=0): `ack[w]`=1 this cycle. Access performed at the edge. `last` ← w. Stay IDLE.
- Misaligned wide access (addr[0]=1): this cycle `ack`=0 and the low byte at addr is accessed. State ← SPLIT with w and the command latched.
- SPLIT: `ack[w]`=1; byte at (addr+1) mod DEPTH accessed. `last` ← w; → IDLE. No other channel is granted in SPLIT.
- Byte order: little-endian. Low byte at addr, high byte at addr+1. All addresses wrap modulo DEPTH; upper address bits beyond log2(DEPTH) are ignored.
- Narrow write stores din[7:0]. Narrow read returns {8'h00, byte}.
- Reads: `dout`, `dout_ch` = w and `dout_valid`=1 in the cycle after the cycle with `ack[w]`.
- Writes never raise `dout_valid`.
- RAM contents are not reset; power-up contents are undefined.

## Timing
- Reset: state IDLE, `last` = CHANNELS-1 (channel 0 wins first), `dout` = 0, `dout_valid` = 0, `dout_ch` = 0. `ack` is forced 0 while `reset` is high.
- Reset during SPLIT abandons the access. The low byte of a misaligned write may already be written. No `ack` and no `dout_valid` for it.
- Latency, aligned: request-to-ack 0 cycles when uncontended; read data +1 cycle.
- Latency, misaligned wide: ack after 1 cycle; data +1 cycle after that.
- Throughput: one aligned access per cycle. Back-to-back requests from one channel are allowed when other channels are idle.
- Fairness: with all CHANNELS requesting continuously, each channel is acked once every CHANNELS grants.
- A channel must not change `wr`, `wide`, `addr` or `din` while `req` is high and `ack` is low. Dropping `req` before `ack` withdraws the request, except in SPLIT, where the grant completes regardless.
- Read-after-write to the same byte in consecutive cycles returns the new data (write-first).

## Configuration
- `MEM_ARBITER_PRIO0_EN` defined: channel 0 has fixed absolute priority. It wins IDLE arbitration whenever `req[0]`=1; channels 1..CHANNELS-1 round-robin among themselves using `last`. A request from channel 0 does not pre-empt a SPLIT in progress.
- Undefined: plain round-robin across all channels as described above.

## Test plan
- After reset, ch0 wide write 16'hBEEF at 16'h0010, then ch1 narrow read 16'h0011 -> ack[0] same cycle; next read gives dout=16'h00BE, dout_valid=1, dout_ch=1.
- ch0 misaligned wide write 16'h1234 at DEPTH-1, then wide read at DEPTH-1 -> byte DEPTH-1 = 8'h34, byte 0 = 8'h12 (wrap). Write ack one cycle after req. Read dout=16'h1234 two cycles after its req.
- All CHANNELS=4 holding `req` on aligned reads -> ack order 0,1,2,3,0,...; each dout_ch matches the previous ack.
- Misaligned wide read on ch1 while ch0 requests -> ch0 ack is withheld during SPLIT and ch0 is acked in the following cycle.
- Assert `reset` during SPLIT -> ack stays 0, no dout_valid; after release, ch0 wins first.
- With `MEM_ARBITER_PRIO0_EN`, ch0 requesting continuously plus ch1/ch2 -> ch0 acked every IDLE cycle; ch1/ch2 starve until ch0 drops, then alternate 1,2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared byte-organised RAM behind a round-robin arbiter with narrow/wide, misaligned-capable access.
// Define MEM_ARBITER_PRIO0_EN to give channel 0 fixed absolute priority in IDLE arbitration.
module mem_arbiter #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 65536,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      req,
  input  logic [CHANNELS-1:0]      wr,
  input  logic [CHANNELS-1:0]      wide,
  input  logic [CHANNELS*ADDR_W-1:0] addr,
  input  logic [CHANNELS*16-1:0]   din,
  output logic [CHANNELS-1:0]      ack,
  output logic [15:0]              dout,
  output logic                     dout_valid,
  output logic [CH_W-1:0]          dout_ch
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW - 1;

  typedef enum logic {IDLE, SPLIT} state_t;

  // Even bytes in bank0, odd bytes in bank1: an aligned wide access touches each bank once.
  logic [7:0] bank0 [DEPTH/2];
  logic [7:0] bank1 [DEPTH/2];

  state_t          state_q, state_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [CH_W-1:0] sch_q, sch_d;
  logic            swr_q, swr_d;
  logic [IW-1:0]   sidx_q, sidx_d;
  logic [7:0]      shi_q, shi_d;
  logic [7:0]      lo_q, lo_d;
  logic [15:0]     dout_q, dout_d;
  logic            dv_q, dv_d;
  logic [CH_W-1:0] dch_q, dch_d;

  logic [CHANNELS-1:0] ack_int;
  logic [CH_W-1:0]     win;
  logic                found;
  logic [AW-1:0]       w_a;
  logic [15:0]         w_din;
  logic                w_wr, w_wide;
  logic [IW-1:0]       idx0, idx1;
  logic                we0, we1;
  logic [7:0]          wd0, wd1, rd0, rd1;
  logic                unused_addr;

  assign unused_addr = ^addr;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      int unsigned c;
      c = (32'(last_q) + k) % CHANNELS;
`ifdef MEM_ARBITER_PRIO0_EN
      if (!found && req[c] && c != 0) begin
`else
      if (!found && req[c]) begin
`endif
        found = 1'b1;
        win   = CH_W'(c);
      end
    end
`ifdef MEM_ARBITER_PRIO0_EN
    if (req[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
  end

  assign w_a    = addr[int'(win)*ADDR_W +: AW];
  assign w_din  = din[int'(win)*16 +: 16];
  assign w_wr   = wr[win];
  assign w_wide = wide[win];
  assign rd0    = bank0[idx0];
  assign rd1    = bank1[idx1];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sch_d   = sch_q;
    swr_d   = swr_q;
    sidx_d  = sidx_q;
    shi_d   = shi_q;
    lo_d    = lo_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    dch_d   = dch_q;
    ack_int = '0;
    idx0    = w_a[AW-1:1];
    idx1    = w_a[AW-1:1];
    we0     = 1'b0;
    we1     = 1'b0;
    wd0     = w_din[7:0];
    wd1     = w_din[15:8];
    unique case (state_q)
      IDLE: begin
        if (found) begin
          if (w_wide && w_a[0]) begin
            // Low byte lives in the odd bank now; high byte is the next even byte, taken in SPLIT.
            wd1     = w_din[7:0];
            we1     = w_wr;
            lo_d    = w_wr ? lo_q : rd1;
            sidx_d  = w_a[AW-1:1] + IW'(1);
            shi_d   = w_din[15:8];
            swr_d   = w_wr;
            sch_d   = win;
            state_d = SPLIT;
          end else begin
            ack_int[win] = 1'b1;
            last_d       = win;
            if (w_wide) begin
              we0    = w_wr;
              we1    = w_wr;
              dout_d = w_wr ? dout_q : {rd1, rd0};
            end else begin
              wd1    = w_din[7:0];
              we0    = w_wr && !w_a[0];
              we1    = w_wr &&  w_a[0];
              dout_d = w_wr ? dout_q : {8'h00, (w_a[0] ? rd1 : rd0)};
            end
            dv_d  = !w_wr;
            dch_d = w_wr ? dch_q : win;
          end
        end
      end
      SPLIT: begin
        ack_int[sch_q] = 1'b1;
        last_d         = sch_q;
        idx0           = sidx_q;
        wd0            = shi_q;
        we0            = swr_q;
        dout_d         = swr_q ? dout_q : {rd0, lo_q};
        dv_d           = !swr_q;
        dch_d          = swr_q ? dch_q : sch_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      we0 = 1'b0;
      we1 = 1'b0;
    end
  end

  assign ack        = reset ? '0 : ack_int;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign dout_ch    = dch_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= CH_W'(CHANNELS - 1);
      sch_q   <= '0;
      swr_q   <= 1'b0;
      sidx_q  <= '0;
      shi_q   <= '0;
      lo_q    <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      dch_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sch_q   <= sch_d;
      swr_q   <= swr_d;
      sidx_q  <= sidx_d;
      shi_q   <= shi_d;
      lo_q    <= lo_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      dch_q   <= dch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) bank0[idx0] <= wd0;
    if (we1) bank1[idx1] <= wd1;
  end

endmodule
